a1csa_pipe: RTL and testbench

Parametrised, pipelined add-one carry-select adder for wide operands, with add/subtract mode and a valid/ready stream interface. Operands are split into `M`-bit blocks; each pipeline stage resolves one block with the add-one carry-select scheme and hands its carry to the next stage. Operand and result bits are skewed so that all bits of a result emerge aligned. The block is the registered, streaming successor of the hierarchical combinational `a1csah*` adders, for datapaths above 128 bits that must close timing at a high clock rate.

---
 rtl/a1csa_pipe.sv | 141 ++++++++++++++
 tb/tb_a1csa_pipe.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/a1csa_pipe.sv
// a1csa_pipe: pipelined add-one carry-select adder/subtractor, N bits wide,
// resolving one M-bit block per stage (S = N/M stages) behind an input register.
// Ports:
//   clk, rst             clock, async active-high reset
//   in_valid/in_ready    operand handshake (in_ready = global advance)
//   sub, cin, a, b       mode, carry in (add only), operands
//   out_valid/out_ready  result handshake
//   s, cout, gen, prop   sum/difference, carry out, group generate/propagate
//   ovf                  signed overflow
module a1csa_pipe #(
    parameter int N = 256,
    parameter int M = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         sub,
    input  logic         cin,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] s,
    output logic         cout,
    output logic         gen,
    output logic         prop,
    output logic         ovf
);

    localparam int S = N / M;

    // Level i is the register in front of stage i; level S holds the result.
    // Operand blocks ride along unchanged until their stage uses them, and
    // resolved sum blocks ride along until the last level, which gives the
    // input/output skew without separate delay lines.
    logic         v_q [0:S];
    logic         v_d [0:S];
    logic         c_q [0:S];
    logic         c_d [0:S];
    logic         g_q [0:S];
    logic         g_d [0:S];
    logic         p_q [0:S];
    logic         p_d [0:S];
    logic [N-1:0] s_q [0:S];
    logic [N-1:0] s_d [0:S];
    logic [N-1:0] a_q [0:S-1];
    logic [N-1:0] a_d [0:S-1];
    logic [N-1:0] e_q [0:S-1];
    logic [N-1:0] e_d [0:S-1];
    logic         o_q;
    logic         o_d;
    logic         adv;

    assign adv      = !v_q[S] | out_ready;
    assign in_ready = adv;

    // Level 0: effective operand and carry; G starts at 0, P at 1.
    assign v_d[0] = in_valid;
    assign c_d[0] = sub | cin;
    assign g_d[0] = 1'b0;
    assign p_d[0] = 1'b1;
    assign s_d[0] = '0;
    assign a_d[0] = a;
    assign e_d[0] = b ^ {N{sub}};

    for (genvar k = 0; k < S; k++) begin : g_stage
        logic [M-1:0] ak;
        logic [M-1:0] bk;
        logic [M:0]   t;
        logic [M-1:0] t1;
        logic [M-1:0] sel;
        logic         gk;
        logic         pk;
        logic         ck;
        logic [N-1:0] bm;

        assign ak  = a_q[k][k*M +: M];
        assign bk  = e_q[k][k*M +: M];
        // Both candidates exist before the carry arrives; the carry only muxes.
        assign t   = {1'b0, ak} + {1'b0, bk};
        assign t1  = t[M-1:0] + M'(1);
        assign sel = c_q[k] ? t1 : t[M-1:0];
        assign gk  = t[M];
        assign pk  = &(ak ^ bk);
        assign ck  = gk | (pk & c_q[k]);
        assign bm  = N'({M{1'b1}}) << (k*M);

        assign v_d[k+1] = v_q[k];
        assign c_d[k+1] = ck;
        assign g_d[k+1] = gk | (pk & g_q[k]);
        assign p_d[k+1] = pk & p_q[k];
        assign s_d[k+1] = (s_q[k] & ~bm) | (N'(sel) << (k*M));

        if (k < S-1) begin : g_fwd
            assign a_d[k+1] = a_q[k];
            assign e_d[k+1] = e_q[k];
        end else begin : g_last
            // Carry into the MSB recovered from its sum bit: a ^ b ^ s.
            assign o_d = (ak[M-1] ^ bk[M-1] ^ sel[M-1]) ^ ck;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= S; i++) begin
                v_q[i] <= 1'b0;
                c_q[i] <= 1'b0;
                g_q[i] <= 1'b0;
                p_q[i] <= 1'b0;
                s_q[i] <= '0;
            end
            for (int i = 0; i < S; i++) begin
                a_q[i] <= '0;
                e_q[i] <= '0;
            end
            o_q <= 1'b0;
        end else if (adv) begin
            for (int i = 0; i <= S; i++) begin
                v_q[i] <= v_d[i];
                c_q[i] <= c_d[i];
                g_q[i] <= g_d[i];
                p_q[i] <= p_d[i];
                s_q[i] <= s_d[i];
            end
            for (int i = 0; i < S; i++) begin
                a_q[i] <= a_d[i];
                e_q[i] <= e_d[i];
            end
            o_q <= o_d;
        end
    end

    assign out_valid = v_q[S];
    assign s         = s_q[S];
    assign cout      = c_q[S];
    assign gen       = g_q[S];
    assign prop      = p_q[S];
    assign ovf       = o_q;

endmodule

// File: tb/tb_a1csa_pipe.sv
// Testbench for a1csa_pipe: directed cases on N=256/M=64, then random
// streaming on 256/64, 96/32 and 64/64 against an arithmetic reference model.
module tb_a1csa_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic         iv0, ir0, sb0, ci0, ov0, or0, co0, gn0, pr0, of0;
    logic [255:0] a0, b0, s0;
    logic         iv1, ir1, sb1, ci1, ov1, or1, co1, gn1, pr1, of1;
    logic [95:0]  a1, b1, s1;
    logic         iv2, ir2, sb2, ci2, ov2, or2, co2, gn2, pr2, of2;
    logic [63:0]  a2, b2, s2;

    logic [259:0] q0[$];
    logic [259:0] q1[$];
    logic [259:0] q2[$];
    logic [259:0] held;

    a1csa_pipe #(.N(256), .M(64)) u0 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0),
        .sub(sb0), .cin(ci0), .a(a0), .b(b0),
        .out_valid(ov0), .out_ready(or0), .s(s0),
        .cout(co0), .gen(gn0), .prop(pr0), .ovf(of0));

    a1csa_pipe #(.N(96), .M(32)) u1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1),
        .sub(sb1), .cin(ci1), .a(a1), .b(b1),
        .out_valid(ov1), .out_ready(or1), .s(s1),
        .cout(co1), .gen(gn1), .prop(pr1), .ovf(of1));

    a1csa_pipe #(.N(64), .M(64)) u2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2),
        .sub(sb2), .cin(ci2), .a(a2), .b(b2),
        .out_valid(ov2), .out_ready(or2), .s(s2),
        .cout(co2), .gen(gn2), .prop(pr2), .ovf(of2));

    // Result layout: {ovf, prop, gen, cout, s[255:0]}
    function automatic logic [259:0] pack(input logic o, p, g, c,
                                          input logic [255:0] sm);
        return {o, p, g, c, sm};
    endfunction

    // Plain-arithmetic reference for an n-bit adder/subtractor.
    function automatic logic [259:0] model(input logic [255:0] a, b,
                                           input logic sub, cin,
                                           input int n);
        logic [256:0] mask, full, raw;
        logic [255:0] am, be, sm;
        logic ce, ov, pr;
        mask = (257'd1 << n) - 257'd1;
        am   = a & mask[255:0];
        be   = (sub ? ~b : b) & mask[255:0];
        ce   = sub | cin;
        full = {1'b0, am} + {1'b0, be} + 257'(ce);
        raw  = {1'b0, am} + {1'b0, be};
        sm   = full[255:0] & mask[255:0];
        pr   = ((am ^ be) & mask[255:0]) == mask[255:0];
        ov   = (am[n-1] == be[n-1]) && (sm[n-1] != am[n-1]);
        return {ov, pr, raw[n], full[n], sm};
    endfunction

    function automatic logic [255:0] rnd();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        if ($urandom_range(0, 7) == 0) r = '1;
        if ($urandom_range(0, 9) == 0) r = '0;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [259:0] obs,
                       input logic [259:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One operand pair into an empty u0, measure latency and check result.
    task automatic run0(input string tag, input logic [255:0] a, b,
                        input logic sb, ci, input logic [259:0] exp);
        int lat;
        iv0 = 1'b1; a0 = a; b0 = b; sb0 = sb; ci0 = ci; or0 = 1'b1;
        @(posedge clk); #1;
        iv0 = 1'b0;
        lat = 0;
        while (!ov0 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"}, 260'(lat), 260'(4));
        chk(tag, pack(of0, pr0, gn0, co0, s0), exp);
        @(posedge clk); #1;
    endtask

    // One cycle of scoreboarding on all three instances.
    task automatic tick3();
        #1;
        if (ov0 && or0) begin
            chk("rr0_nonempty", 260'(q0.size() != 0), 260'(1));
            if (q0.size() != 0)
                chk("rr0", pack(of0, pr0, gn0, co0, s0), q0.pop_front());
        end
        if (ov1 && or1) begin
            chk("rr1_nonempty", 260'(q1.size() != 0), 260'(1));
            if (q1.size() != 0)
                chk("rr1", pack(of1, pr1, gn1, co1, 256'(s1)), q1.pop_front());
        end
        if (ov2 && or2) begin
            chk("rr2_nonempty", 260'(q2.size() != 0), 260'(1));
            if (q2.size() != 0)
                chk("rr2", pack(of2, pr2, gn2, co2, 256'(s2)), q2.pop_front());
        end
        if (iv0 && ir0) q0.push_back(model(a0, b0, sb0, ci0, 256));
        if (iv1 && ir1) q1.push_back(model(256'(a1), 256'(b1), sb1, ci1, 96));
        if (iv2 && ir2) q2.push_back(model(256'(a2), 256'(b2), sb2, ci2, 64));
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int sent, got;
        logic [255:0] x;
        rst = 1'b1;
        iv0 = 0; sb0 = 0; ci0 = 0; or0 = 1; a0 = '0; b0 = '0;
        iv1 = 0; sb1 = 0; ci1 = 0; or1 = 1; a1 = '0; b1 = '0;
        iv2 = 0; sb2 = 0; ci2 = 0; or2 = 1; a2 = '0; b2 = '0;
        #2;
        chk("rst_ctl", 260'({ir0, ov0}), 260'(2'b10));
        chk("rst_data", pack(of0, pr0, gn0, co0, s0), '0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        run0("add_ones", '1, '0, 1'b0, 1'b1,
             pack(1'b0, 1'b1, 1'b0, 1'b1, '0));
        run0("sub_5_7", 256'd5, 256'd7, 1'b1, 1'b0,
             pack(1'b0, 1'b0, 1'b0, 1'b0, ~256'd1));
        run0("sub_7_5", 256'd7, 256'd5, 1'b1, 1'b1,
             pack(1'b0, 1'b0, 1'b1, 1'b1, 256'd2));
        x = 256'd1 << 255;
        run0("ovf_pos", x - 256'd1, 256'd1, 1'b0, 1'b0,
             pack(1'b1, 1'b0, 1'b0, 1'b0, x));
        run0("ovf_neg", x, x, 1'b0, 1'b0,
             pack(1'b1, 1'b0, 1'b1, 1'b1, '0));

        // Back-pressure: 10 pairs streamed, 3-cycle stall mid-stream.
        sent = 0; got = 0;
        for (int cyc = 0; cyc < 60 && got < 10; cyc++) begin
            iv0 = (sent < 10);
            a0 = rnd(); b0 = rnd();
            sb0 = 1'($urandom_range(0, 1)); ci0 = 1'($urandom_range(0, 1));
            or0 = !(cyc >= 6 && cyc < 9);
            #1;
            if (!or0) begin
                chk("bp_in_ready", 260'(ir0), 260'(0));
                chk("bp_out_valid", 260'(ov0), 260'(1));
                if (cyc == 6) held = pack(of0, pr0, gn0, co0, s0);
                else chk("bp_hold", pack(of0, pr0, gn0, co0, s0), held);
            end
            if (ov0 && or0) begin
                chk("bp_nonempty", 260'(q0.size() != 0), 260'(1));
                if (q0.size() != 0)
                    chk("bp_res", pack(of0, pr0, gn0, co0, s0), q0.pop_front());
                got++;
            end
            if (iv0 && ir0) begin
                q0.push_back(model(a0, b0, sb0, ci0, 256));
                sent++;
            end
            @(posedge clk); #1;
        end
        iv0 = 1'b0; or0 = 1'b1;
        chk("bp_count", 260'(got), 260'(10));

        // Reset with results in flight.
        for (int i = 0; i < 5; i++) begin
            iv0 = 1'b1; a0 = rnd(); b0 = rnd(); sb0 = 1'b0; ci0 = 1'b0;
            @(posedge clk); #1;
        end
        iv0 = 1'b0;
        chk("rst_pre_valid", 260'(ov0), 260'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_ctl", 260'({ir0, ov0}), 260'(2'b10));
        chk("rst_async_data", pack(of0, pr0, gn0, co0, s0), '0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            chk("rst_stale", 260'(ov0), 260'(0));
            @(posedge clk); #1;
        end
        run0("post_rst", 256'd100, 256'd23, 1'b0, 1'b1,
             pack(1'b0, 1'b0, 1'b0, 1'b0, 256'd124));

        // Random regression on all three geometries.
        for (int cyc = 0; cyc < 400; cyc++) begin
            iv0 = ($urandom_range(0, 3) != 0); or0 = ($urandom_range(0, 3) != 0);
            iv1 = ($urandom_range(0, 3) != 0); or1 = ($urandom_range(0, 3) != 0);
            iv2 = ($urandom_range(0, 3) != 0); or2 = ($urandom_range(0, 3) != 0);
            a0 = rnd(); b0 = rnd();
            a1 = 96'(rnd()); b1 = 96'(rnd());
            a2 = 64'(rnd()); b2 = 64'(rnd());
            sb0 = 1'($urandom_range(0, 1)); ci0 = 1'($urandom_range(0, 1));
            sb1 = 1'($urandom_range(0, 1)); ci1 = 1'($urandom_range(0, 1));
            sb2 = 1'($urandom_range(0, 1)); ci2 = 1'($urandom_range(0, 1));
            tick3();
        end
        iv0 = 0; iv1 = 0; iv2 = 0;
        or0 = 1; or1 = 1; or2 = 1;
        for (int i = 0; i < 10; i++) tick3();
        chk("rr0_drained", 260'(q0.size()), 260'(0));
        chk("rr1_drained", 260'(q1.size()), 260'(0));
        chk("rr2_drained", 260'(q2.size()), 260'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
